conv_coeff_seq: RTL and testbench

Synthesizable generator for convolution filter coefficients, for a KxK kernel of configurable size. It drives the fc_valid / fc coefficient stream into the convolution engine, one coefficient per accepted cycle in raster order. It has built-in kernels and a programmable coefficient bank, and adds ready/valid back-pressure.

---
 rtl/conv_coeff_seq_if.sv | 29 ++
 rtl/conv_coeff_seq.sv | 123 ++++++++++++
 tb/tb_conv_coeff_seq.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/conv_coeff_seq_if.sv
// Handshake, configuration and coefficient-stream signals of conv_coeff_seq.
// master drives start/config/fc_ready; slave (the sequencer) drives the stream.
interface conv_coeff_seq_if #(
  parameter int unsigned COEF_W = 8,
  parameter int unsigned AW     = 7
);
  logic                     start;
  logic [1:0]               mode;
  logic                     cfg_we;
  logic [AW-1:0]            cfg_addr;
  logic signed [COEF_W-1:0] cfg_data;
  logic                     fc_ready;
  logic                     fc_valid;
  logic signed [COEF_W-1:0] fc;
  logic [3:0]               fc_row;
  logic [3:0]               fc_col;
  logic                     busy;
  logic                     done;

  modport master (
    output start, mode, cfg_we, cfg_addr, cfg_data, fc_ready,
    input  fc_valid, fc, fc_row, fc_col, busy, done
  );

  modport slave (
    input  start, mode, cfg_we, cfg_addr, cfg_data, fc_ready,
    output fc_valid, fc, fc_row, fc_col, busy, done
  );
endinterface

// File: rtl/conv_coeff_seq.sv
// KxK convolution coefficient sequencer: streams one coefficient per accepted beat in
// raster order from a built-in kernel or a programmable bank, with ready/valid back-pressure.
module conv_coeff_seq #(
  parameter int unsigned K      = 5,
  parameter int unsigned COEF_W = 8,
  parameter int unsigned AW     = 7
) (
  input logic             clk,
  input logic             rst_n,
  conv_coeff_seq_if.slave bus
);
  localparam int unsigned N  = K * K;
  localparam int unsigned IW = $clog2(N);
  localparam int unsigned C  = (K - 1) / 2;

  typedef enum logic [1:0] {StIdle, StStream, StDone} state_e;

  state_e                   state_q;
  logic [1:0]               mode_q;
  logic [3:0]               row_q, col_q;
  logic                     fc_valid_q, busy_q, done_q;
  logic signed [COEF_W-1:0] fc_q;
  logic signed [COEF_W-1:0] bank_q [N];

  logic                     wr_en, start_ok, last;
  logic [3:0]               nxt_row, nxt_col, lk_row, lk_col;
  logic [1:0]               lk_mode;
  logic [IW-1:0]            lk_idx;
  logic                     lk_centre;
  logic signed [COEF_W-1:0] lk_bank, lk_coef;

  always_comb begin
    wr_en    = bus.cfg_we && (state_q != StStream) && (32'(bus.cfg_addr) < N);
    start_ok = (state_q == StIdle) && bus.start;
    last     = (32'(row_q) == K - 1) && (32'(col_q) == K - 1);

    if (32'(col_q) == K - 1) begin
      nxt_col = '0;
      nxt_row = row_q + 4'd1;
    end else begin
      nxt_col = col_q + 4'd1;
      nxt_row = row_q;
    end

    // The lookup targets the coefficient that will be presented after this edge.
    if (start_ok) begin
      lk_mode = bus.mode;
      lk_row  = '0;
      lk_col  = '0;
    end else begin
      lk_mode = mode_q;
      lk_row  = nxt_row;
      lk_col  = nxt_col;
    end

    lk_idx  = IW'(32'(lk_row) * K + 32'(lk_col));
    lk_bank = '0;
    if (32'(lk_idx) < N) lk_bank = bank_q[lk_idx];
    // A write coinciding with start must be visible to the first beat.
    if (wr_en && (32'(bus.cfg_addr) == 32'(lk_idx))) lk_bank = bus.cfg_data;

    lk_centre = (32'(lk_row) == C) && (32'(lk_col) == C);
    unique case (lk_mode)
      2'd0:    lk_coef = lk_centre ? COEF_W'(N - 1) : '1;
      2'd1:    lk_coef = COEF_W'(1);
      2'd2:    lk_coef = lk_centre ? COEF_W'(1) : '0;
      default: lk_coef = lk_bank;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      mode_q     <= '0;
      row_q      <= '0;
      col_q      <= '0;
      fc_q       <= '0;
      fc_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      for (int unsigned i = 0; i < N; i++) bank_q[i] <= '0;
    end else begin
      if (wr_en) bank_q[IW'(bus.cfg_addr)] <= bus.cfg_data;
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start_ok) begin
            state_q    <= StStream;
            mode_q     <= bus.mode;
            row_q      <= '0;
            col_q      <= '0;
            fc_q       <= lk_coef;
            fc_valid_q <= 1'b1;
            busy_q     <= 1'b1;
          end
        end
        StStream: begin
          if (bus.fc_ready) begin
            if (last) begin
              state_q    <= StDone;
              fc_valid_q <= 1'b0;
              busy_q     <= 1'b0;
              done_q     <= 1'b1;
            end else begin
              row_q <= nxt_row;
              col_q <= nxt_col;
              fc_q  <= lk_coef;
            end
          end
        end
        StDone: state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.fc_valid = fc_valid_q;
  assign bus.fc       = fc_q;
  assign bus.fc_row   = row_q;
  assign bus.fc_col   = col_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
endmodule

// File: tb/tb_conv_coeff_seq.sv
// Drives K=5, K=3 and K=7 sequencers with shared stimulus; each is checked every cycle
// against a beat-index reference model.
module tb_conv_coeff_seq;
  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             start, cfg_we, fc_ready;
  logic [1:0]       mode;
  logic [6:0]       cfg_addr;
  logic signed [7:0] cfg_data;

  int n_vec = 0;
  int n_err = 0;
  int cnt [3];

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", tag, got, exp);
    end
  endtask

  function automatic int ref_coef(input int k, input int m, input int beat, input int bankv);
    int r   = beat / k;
    int c   = beat % k;
    int ctr = (k - 1) / 2;
    bit cen = (r == ctr) && (c == ctr);
    case (m)
      0:       return cen ? k * k - 1 : -1;
      1:       return 1;
      2:       return cen ? 1 : 0;
      default: return bankv;
    endcase
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int KK  = (g == 0) ? 5 : (g == 1) ? 3 : 7;
    localparam int TOT = KK * KK;

    conv_coeff_seq_if #(.COEF_W(8), .AW(7)) bus ();
    assign bus.start    = start;
    assign bus.mode     = mode;
    assign bus.cfg_we   = cfg_we;
    assign bus.cfg_addr = cfg_addr;
    assign bus.cfg_data = cfg_data;
    assign bus.fc_ready = fc_ready;

    conv_coeff_seq #(.K(KK), .COEF_W(8), .AW(7)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
    );

    // Reference: a stream is just a beat counter 0..TOT-1 plus a latched mode.
    bit m_active = 1'b0;
    bit m_done   = 1'b0;
    int m_beat   = 0;
    int m_mode   = 0;
    int m_bank [TOT];

    always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        m_active <= 1'b0;
        m_done   <= 1'b0;
        m_beat   <= 0;
        m_mode   <= 0;
        for (int i = 0; i < TOT; i++) m_bank[i] <= 0;
      end else begin
        m_done <= m_active && fc_ready && (m_beat == TOT - 1);
        if (!m_active && cfg_we && int'(cfg_addr) < TOT)
          m_bank[int'(cfg_addr)] <= int'($signed(cfg_data));
        if (m_active && fc_ready) begin
          m_beat <= m_beat + 1;
          if (m_beat == TOT - 1) m_active <= 1'b0;
        end else if (!m_active && !m_done && start) begin
          m_active <= 1'b1;
          m_beat   <= 0;
          m_mode   <= int'(mode);
        end
      end
    end

    always @(negedge clk) begin
      chk($sformatf("k%0d_valid", KK), int'(bus.fc_valid), int'(m_active));
      chk($sformatf("k%0d_busy", KK), int'(bus.busy), int'(m_active));
      chk($sformatf("k%0d_done", KK), int'(bus.done), int'(m_done));
      if (m_active) begin
        chk($sformatf("k%0d_fc_b%0d", KK, m_beat), int'($signed(bus.fc)),
            ref_coef(KK, m_mode, m_beat, m_bank[m_beat]));
        chk($sformatf("k%0d_row_b%0d", KK, m_beat), int'(bus.fc_row), m_beat / KK);
        chk($sformatf("k%0d_col_b%0d", KK, m_beat), int'(bus.fc_col), m_beat % KK);
      end
    end
  end

  function automatic bit any_pending();
    return g_dut[0].m_active || g_dut[0].m_done || g_dut[1].m_active || g_dut[1].m_done ||
           g_dut[2].m_active || g_dut[2].m_done;
  endfunction

  task automatic kick(input logic [1:0] m);
    @(negedge clk);
    mode  = m;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    mode  = 2'($urandom);  // must not affect the running stream
  endtask

  // kind 0: always ready, 1: random ready/start/config, 2: stalls at beats 3 and 20 (K=5)
  task automatic drain(input int kind, input int max_cyc);
    int n   = 0;
    int s3  = 0;
    int s20 = 0;
    cnt = '{0, 0, 0};
    do begin
      cnt[0] += int'(g_dut[0].bus.fc_valid);
      cnt[1] += int'(g_dut[1].bus.fc_valid);
      cnt[2] += int'(g_dut[2].bus.fc_valid);
      @(negedge clk);
      n++;
      case (kind)
        1: begin
          fc_ready = 1'($urandom_range(0, 1));
          start    = (n < 12) && ($urandom_range(0, 3) == 0);
          mode     = 2'($urandom);
          cfg_we   = ($urandom_range(0, 2) == 0);
          cfg_addr = 7'($urandom_range(0, 60));
          cfg_data = 8'($urandom);
        end
        2: begin
          if (g_dut[0].m_active && g_dut[0].m_beat == 2 && s3 < 2) begin
            fc_ready = 1'b0;
            s3++;
          end else if (g_dut[0].m_active && g_dut[0].m_beat == 19 && s20 < 5) begin
            fc_ready = 1'b0;
            s20++;
          end else begin
            fc_ready = 1'b1;
          end
        end
        default: fc_ready = 1'b1;
      endcase
    end while (any_pending() && n < max_cyc);
    start    = 1'b0;
    cfg_we   = 1'b0;
    fc_ready = 1'b1;
    chk("drain_bound", int'(n < max_cyc), 1);
  endtask

  initial begin
    start = 1'b0; mode = '0; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0; fc_ready = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_valid", int'(g_dut[0].bus.fc_valid), 0);
    chk("rst_busy", int'(g_dut[0].bus.busy), 0);
    chk("rst_done", int'(g_dut[0].bus.done), 0);
    chk("rst_fc", int'(g_dut[0].bus.fc), 0);
    chk("rst_row", int'(g_dut[0].bus.fc_row), 0);
    chk("rst_col", int'(g_dut[0].bus.fc_col), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Laplacian, full throughput: exactly K*K valid cycles on every instance
    kick(2'd0);
    drain(0, 200);
    chk("t1_beats_k5", cnt[0], 25);
    chk("t1_beats_k3", cnt[1], 9);
    chk("t1_beats_k7", cnt[2], 49);

    // Programmed ramp -12..12 with stalls
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      cfg_we   = 1'b1;
      cfg_addr = 7'(i);
      cfg_data = 8'(i - 12);
    end
    @(negedge clk);
    cfg_we = 1'b0;
    kick(2'd3);
    drain(2, 200);
    chk("t2_valid_cycles_k5", cnt[0], 25 + 7);

    // Laplacian under random back-pressure
    kick(2'd0);
    drain(1, 400);

    // Identity with a restart attempt and a bank write mid-stream, then read bank back
    kick(2'd2);
    repeat (4) @(negedge clk);
    start = 1'b1; mode = 2'd3; cfg_we = 1'b1; cfg_addr = '0; cfg_data = 8'sd55;
    @(negedge clk);
    start = 1'b0; cfg_we = 1'b0;
    drain(0, 200);
    kick(2'd3);
    drain(0, 200);

    // Asynchronous reset at beat 10
    kick(2'd1);
    for (int n = 0; n < 60 && g_dut[0].m_beat != 9; n++) @(negedge clk);
    chk("t5_reach_beat10", g_dut[0].m_beat, 9);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_async_valid", int'(g_dut[0].bus.fc_valid), 0);
    chk("t5_async_busy", int'(g_dut[0].bus.busy), 0);
    chk("t5_async_fc", int'(g_dut[0].bus.fc), 0);
    chk("t5_async_row", int'(g_dut[0].bus.fc_row), 0);
    chk("t5_async_valid_k7", int'(g_dut[2].bus.fc_valid), 0);
    @(negedge clk);
    rst_n = 1'b1;
    kick(2'd1);
    drain(0, 200);
    chk("t5_beats_k5", cnt[0], 25);

    // Out-of-range write (ignored for K=5), bank cleared by reset
    @(negedge clk);
    cfg_we = 1'b1; cfg_addr = 7'd30; cfg_data = 8'sd77;
    @(negedge clk);
    cfg_we = 1'b0;
    kick(2'd3);
    drain(0, 200);

    // Write and start in the same cycle: first beat sees the new value
    @(negedge clk);
    cfg_we = 1'b1; cfg_addr = '0; cfg_data = -8'sd7; mode = 2'd3; start = 1'b1;
    @(negedge clk);
    cfg_we = 1'b0; start = 1'b0;
    drain(0, 200);

    for (int r = 0; r < 8; r++) begin
      kick(2'($urandom));
      drain(1, 400);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, want finish");
    $fatal(1);
  end
endmodule
